// File: rtl/hdmi_overlay_mixer.sv
// Overlay compositor between the pixel timing stage and the HDMI pins; build option OVERLAY_CHROMA_KEY_EN adds key_rgb transparency.
// Latency: fixed 2 cycles from timing/coordinate/background inputs to every output, no bubbles.
// Backpressure: video path never stalls; overlay stream is popped only on in-window pixels, or drained while hunting for SOF.
module hdmi_overlay_mixer #(
    parameter int          hBusWidth    = 12,
    parameter int          vBusWidth    = 12,
    parameter int          ovlWidth     = 320,
    parameter int          ovlHeight    = 240,
    parameter logic [23:0] underflowRgb = 24'hFF00FF
) (
    input  logic                 clock_50,
    input  logic                 masterReset_n,
    input  logic                 de_in,
    input  logic                 hsync_in,
    input  logic                 vsync_in,
    input  logic [hBusWidth-1:0] x_in,
    input  logic [vBusWidth-1:0] y_in,
    input  logic [23:0]          bg_rgb,
    input  logic [hBusWidth-1:0] ovl_x0,
    input  logic [vBusWidth-1:0] ovl_y0,
    input  logic [1:0]           blend_mode,
    input  logic [23:0]          ovl_data,
    input  logic                 ovl_sof,
    input  logic                 ovl_valid,
    output logic                 ovl_ready,
`ifdef OVERLAY_CHROMA_KEY_EN
    input  logic [23:0]          key_rgb,
`endif
    input  logic                 clear_flags,
    output logic                 de_out,
    output logic                 hsync_out,
    output logic                 vsync_out,
    output logic [23:0]          rgb_out,
    output logic                 underflow_flag,
    output logic                 misalign_flag
);

    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_ARMED  = 2'd1,
        ST_ACTIVE = 2'd2
    } state_t;

    // Everything stage 2 needs to form the composite pixel.
    typedef struct packed {
        logic        de;
        logic        hsync;
        logic        vsync;
        logic [1:0]  mode;
        logic        uf;
        logic        pres;
        logic [23:0] bg;
        logic [23:0] ovl;
    } s1_t;

    // Window extents, one bit wider than the coordinates so right/bottom edges never wrap.
    localparam logic [hBusWidth:0] OVL_W_M1 = (hBusWidth+1)'(ovlWidth - 1);
    localparam logic [vBusWidth:0] OVL_H_M1 = (vBusWidth+1)'(ovlHeight - 1);

    state_t               state;
    state_t               state_nxt;
    logic [hBusWidth-1:0] win_x0;
    logic [vBusWidth-1:0] win_y0;
    logic [hBusWidth-1:0] wx0;
    logic [vBusWidth-1:0] wy0;
    logic [hBusWidth:0]   x_ext;
    logic [hBusWidth:0]   x_lo;
    logic [hBusWidth:0]   x_last;
    logic [vBusWidth:0]   y_ext;
    logic [vBusWidth:0]   y_lo;
    logic [vBusWidth:0]   y_last;
    logic                 fs;
    logic                 in_win;
    logic                 first_px;
    logic                 last_px;
    logic                 win_act;
    logic                 rdy_c;
    logic                 pop;
    logic                 key_hit;
    logic                 uf_set;
    logic                 mis_set;
    s1_t                  s1;
    logic [23:0]          mix_rgb;
    logic [8:0]           mix_sum;
    logic [23:0]          comp_rgb;

    // Frame start; the FS pixel itself already sees the new window origin.
    assign fs  = de_in && (x_in == '0) && (y_in == '0);
    assign wx0 = fs ? ovl_x0 : win_x0;
    assign wy0 = fs ? ovl_y0 : win_y0;

    assign x_ext  = {1'b0, x_in};
    assign y_ext  = {1'b0, y_in};
    assign x_lo   = {1'b0, wx0};
    assign y_lo   = {1'b0, wy0};
    assign x_last = x_lo + OVL_W_M1;
    assign y_last = y_lo + OVL_H_M1;

    assign in_win   = de_in && (x_ext >= x_lo) && (x_ext <= x_last)
                            && (y_ext >= y_lo) && (y_ext <= y_last);
    assign first_px = in_win && (x_ext == x_lo) && (y_ext == y_lo);
    assign last_px  = in_win && (x_ext == x_last) && (y_ext == y_last);

    // Window logic runs in ACTIVE, and also on the FS cycle that moves ARMED to ACTIVE.
    // An FS seen while already ACTIVE aborts the frame instead.
    assign win_act = ((state == ST_ACTIVE) && !fs) || ((state == ST_ARMED) && fs);

`ifdef OVERLAY_CHROMA_KEY_EN
    assign key_hit = (ovl_data == key_rgb);
`else
    assign key_hit = 1'b0;
`endif

    assign ovl_ready = masterReset_n && rdy_c;
    assign pop       = ovl_ready && ovl_valid;

    // Next state, pop strobe and flag-set events for the current pixel.
    always_comb begin
        state_nxt = state;
        rdy_c     = 1'b0;
        uf_set    = 1'b0;
        mis_set   = 1'b0;
        case (state)
            ST_HUNT: begin
                rdy_c = ovl_valid && !ovl_sof;
                if (ovl_valid && ovl_sof) begin
                    state_nxt = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (fs) begin
                    state_nxt = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (fs) begin
                    mis_set   = 1'b1;
                    state_nxt = ST_HUNT;
                end
            end
            default: state_nxt = ST_HUNT;
        endcase
        if (win_act && in_win) begin
            if (!ovl_valid) begin
                uf_set    = 1'b1;
                state_nxt = ST_HUNT;
            end else if (ovl_sof && !first_px) begin
                // SOF stays at the head so the next frame can lock onto it.
                mis_set   = 1'b1;
                state_nxt = ST_HUNT;
            end else begin
                rdy_c = 1'b1;
                if (last_px) begin
                    state_nxt = ST_HUNT;
                end
            end
        end
    end

    // State register.
    always_ff @(posedge clock_50 or negedge masterReset_n) begin
        if (!masterReset_n) begin
            state <= ST_HUNT;
        end else begin
            state <= state_nxt;
        end
    end

    // Window origin captured once per frame.
    always_ff @(posedge clock_50 or negedge masterReset_n) begin
        if (!masterReset_n) begin
            win_x0 <= '0;
            win_y0 <= '0;
        end else if (fs) begin
            win_x0 <= ovl_x0;
            win_y0 <= ovl_y0;
        end
    end

    // Sticky error flags; clear wins over a same-cycle set.
    always_ff @(posedge clock_50 or negedge masterReset_n) begin
        if (!masterReset_n) begin
            underflow_flag <= 1'b0;
            misalign_flag  <= 1'b0;
        end else if (clear_flags) begin
            underflow_flag <= 1'b0;
            misalign_flag  <= 1'b0;
        end else begin
            if (uf_set) begin
                underflow_flag <= 1'b1;
            end
            if (mis_set) begin
                misalign_flag <= 1'b1;
            end
        end
    end

    // Stage 1: timing, background, popped overlay pixel and its present bit.
    always_ff @(posedge clock_50 or negedge masterReset_n) begin
        if (!masterReset_n) begin
            s1 <= '0;
        end else begin
            s1.de    <= de_in;
            s1.hsync <= hsync_in;
            s1.vsync <= vsync_in;
            s1.mode  <= blend_mode;
            s1.uf    <= win_act && in_win && !ovl_valid;
            s1.pres  <= win_act && in_win && pop && !key_hit;
            s1.bg    <= bg_rgb;
            s1.ovl   <= ovl_data;
        end
    end

    // 50% mix per channel, 9-bit sum keeps the carry.
    always_comb begin
        mix_rgb = '0;
        mix_sum = '0;
        for (int c = 0; c < 3; c++) begin
            mix_sum            = {1'b0, s1.bg[c*8 +: 8]} + {1'b0, s1.ovl[c*8 +: 8]};
            mix_rgb[c*8 +: 8]  = mix_sum[8:1];
        end
    end

    // Composite selection; blanking forces black, underflow shows the marker colour.
    always_comb begin
        comp_rgb = '0;
        if (!s1.de) begin
            comp_rgb = '0;
        end else if (s1.uf) begin
            comp_rgb = underflowRgb;
        end else begin
            case (s1.mode)
                2'b00:   comp_rgb = s1.bg;
                2'b01:   comp_rgb = s1.pres ? s1.ovl : s1.bg;
                2'b10:   comp_rgb = s1.pres ? mix_rgb : s1.bg;
                default: comp_rgb = s1.pres ? s1.ovl : 24'h0;
            endcase
        end
    end

    // Stage 2: registered outputs.
    always_ff @(posedge clock_50 or negedge masterReset_n) begin
        if (!masterReset_n) begin
            de_out    <= 1'b0;
            hsync_out <= 1'b0;
            vsync_out <= 1'b0;
            rgb_out   <= '0;
        end else begin
            de_out    <= s1.de;
            hsync_out <= s1.hsync;
            vsync_out <= s1.vsync;
            rgb_out   <= comp_rgb;
        end
    end

endmodule
